// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: default geometry,
// the halt opcode and the loader FSM state encoding.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_DEPTH       = 64;
    localparam logic [5:0]  DEF_HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StRun    = 2'd2,
        StHalted = 2'd3
    } state_e;

    // True when the top six bits of a word match the given halt opcode.
    function automatic logic is_halt_opcode(input logic [5:0] opcode,
                                            input logic [5:0] halt_opcode);
        return opcode == halt_opcode;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Instruction storage: one synchronous write port, one registered read port.
// No reset on the array or on the read register.
//
// Ports:
//   i_clock  - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write word index
//   i_wdata  - write data
//   i_re     - read enable; o_rdata holds when low
//   i_raddr  - read word index
//   o_rdata  - registered read data
// -----------------------------------------------------------------------------
module imem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program byte stream (MSB-first per word) into instruction memory,
// then serves registered fetches until a halt opcode is fetched.
//
// Ports:
//   i_clock       - clock, rising edge
//   i_reset       - synchronous active-high reset
//   i_load_start  - begin/restart program load (any state)
//   i_load_valid  - i_load_byte valid
//   i_load_byte   - program byte
//   o_load_ready  - byte accepted when valid and ready (LOAD only)
//   i_fetch_en    - fetch request at i_pc (RUN only)
//   i_pc          - byte address, bits [1:0] ignored
//   o_instruccion - fetched word (zero for indices beyond the program)
//   o_instr_valid - o_instruccion valid this cycle
//   o_halt        - halt opcode fetched, sticky
//   o_loading     - FSM in LOAD
//   o_word_count  - words written in current program
//   o_full        - o_word_count == DEPTH
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    parameter logic [5:0]  HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load_start,
    input  logic                  i_load_valid,
    input  logic [7:0]            i_load_byte,
    output logic                  o_load_ready,
    input  logic                  i_fetch_en,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic                  o_instr_valid,
    output logic                  o_halt,
    output logic                  o_loading,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_full
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned IDX_W  = DATA_WIDTH - 2;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [BCNT_W-1:0]     r_byte_cnt, w_byte_cnt_next;
    logic [DATA_WIDTH-1:0] r_asm, w_asm_next;
    logic [ADDR_WIDTH:0]   r_word_count, w_word_count_next;
    logic                  r_halt, w_halt_next;
    logic                  r_instr_valid, w_instr_valid_next;
    // Forces o_instruccion to zero (reset value and out-of-program NOP) without
    // needing a reset or clear on the RAM read register.
    logic                  r_nop, w_nop_next;

    logic [DATA_WIDTH-1:0] w_asm_shift;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic                  w_byte_last;
    logic                  w_halt_now;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_word_idx;
    logic [DATA_WIDTH-1:0] w_instr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic                  w_pc_unused;

    assign w_pc_unused = ^i_pc[1:0];
    assign w_word_idx  = i_pc[DATA_WIDTH-1:2];
    assign w_instr     = r_nop ? '0 : w_rdata;

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clock (i_clock),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_asm_shift),
        .i_re    (w_ram_re),
        .i_raddr (i_pc[ADDR_WIDTH+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_wr_ptr      <= '0;
            r_byte_cnt    <= '0;
            r_asm         <= '0;
            r_word_count  <= '0;
            r_halt        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_nop         <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_wr_ptr      <= w_wr_ptr_next;
            r_byte_cnt    <= w_byte_cnt_next;
            r_asm         <= w_asm_next;
            r_word_count  <= w_word_count_next;
            r_halt        <= w_halt_next;
            r_instr_valid <= w_instr_valid_next;
            r_nop         <= w_nop_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_wr_ptr_next      = r_wr_ptr;
        w_byte_cnt_next    = r_byte_cnt;
        w_asm_next         = r_asm;
        w_word_count_next  = r_word_count;
        w_halt_next        = r_halt;
        w_instr_valid_next = 1'b0;
        w_nop_next         = r_nop;
        w_ram_we           = 1'b0;
        w_ram_re           = 1'b0;

        w_asm_shift        = r_asm << 8;
        w_asm_shift[7:0]   = i_load_byte;
        w_count_inc        = r_word_count + (ADDR_WIDTH + 1)'(1);
        w_byte_last        = (r_byte_cnt == BCNT_W'(BYTES - 1));
        w_in_range         = (w_word_idx < IDX_W'(r_word_count));
        // Halt is seen the cycle the fetched word is presented, before HALTED.
        w_halt_now         = (r_state == StRun) && r_instr_valid &&
                             is_halt_opcode(w_instr[DATA_WIDTH-1:DATA_WIDTH-6], HALT_OPCODE);

        if (i_load_start) begin
            w_state_next      = StLoad;
            w_wr_ptr_next     = '0;
            w_byte_cnt_next   = '0;
            w_asm_next        = '0;
            w_word_count_next = '0;
            w_halt_next       = 1'b0;
        end else begin
            case (r_state)
                StLoad: begin
                    if (i_load_valid) begin
                        w_asm_next = w_asm_shift;
                        if (w_byte_last) begin
                            w_ram_we          = 1'b1;
                            w_wr_ptr_next     = r_wr_ptr + ADDR_WIDTH'(1);
                            w_word_count_next = w_count_inc;
                            w_byte_cnt_next   = '0;
                            if (is_halt_opcode(w_asm_shift[DATA_WIDTH-1:DATA_WIDTH-6],
                                               HALT_OPCODE) ||
                                (w_count_inc == FULL_COUNT)) begin
                                w_state_next = StRun;
                            end
                        end else begin
                            w_byte_cnt_next = r_byte_cnt + BCNT_W'(1);
                        end
                    end
                end
                StRun: begin
                    if (w_halt_now) begin
                        // Drop any fetch so the halt word stays on o_instruccion.
                        w_state_next = StHalted;
                        w_halt_next  = 1'b1;
                    end else if (i_fetch_en) begin
                        w_instr_valid_next = 1'b1;
                        if (w_in_range) begin
                            w_ram_re   = 1'b1;
                            w_nop_next = 1'b0;
                        end else begin
                            w_nop_next = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_load_ready  = (r_state == StLoad);
    assign o_loading     = (r_state == StLoad);
    assign o_instruccion = w_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_halt        = r_halt | w_halt_now;
    assign o_word_count  = r_word_count;
    assign o_full        = (r_word_count == FULL_COUNT);

endmodule
